// File: rtl/ysyx_22041461_ifu.sv
// Instruction fetch unit: walks one word per instruction through REQ -> WAIT -> HOLD,
// presents it to decode, and picks the next fetch address when the instruction retires.
module ysyx_22041461_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] pc,
    output logic [63:0] snpc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        fetch_err,
    output logic [63:0] inst_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [63:0] fetch_pc_reg, fetch_pc_next;
    logic [31:0] inst_reg, inst_next;
    logic [63:0] pc_reg, pc_next;
    logic [63:0] snpc_reg, snpc_next;
    logic        fetch_err_reg, fetch_err_next;
    logic [63:0] inst_cnt_reg, inst_cnt_next;

    logic        retire;
    logic        misaligned;

    assign retire     = (state_reg == HOLD) && inst_ready;
    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_comb begin
        state_next     = state_reg;
        fetch_pc_next  = fetch_pc_reg;
        inst_next      = inst_reg;
        pc_next        = pc_reg;
        snpc_next      = snpc_reg;
        fetch_err_next = fetch_err_reg;
        inst_cnt_next  = inst_cnt_reg;

        case (state_reg)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (imem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    inst_next  = imem_rsp_data;
                    pc_next    = fetch_pc_reg;
                    snpc_next  = fetch_pc_reg + 64'd4;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (retire) begin
                    inst_next     = NOP_INST;
                    inst_cnt_next = inst_cnt_reg + 64'd1;
                    state_next    = REQ;
                    // Low two bits are dropped so memory only ever sees word addresses.
                    if (redirect_valid) begin
                        fetch_pc_next = {redirect_pc[63:2], 2'b00};
                    end else begin
                        fetch_pc_next = pc_reg + 64'd4;
                    end
                    if (misaligned) begin
                        fetch_err_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            fetch_pc_reg  <= RESET_PC;
            inst_reg      <= NOP_INST;
            pc_reg        <= RESET_PC;
            snpc_reg      <= RESET_PC + 64'd4;
            fetch_err_reg <= 1'b0;
            inst_cnt_reg  <= 64'd0;
        end else begin
            state_reg     <= state_next;
            fetch_pc_reg  <= fetch_pc_next;
            inst_reg      <= inst_next;
            pc_reg        <= pc_next;
            snpc_reg      <= snpc_next;
            fetch_err_reg <= fetch_err_next;
            inst_cnt_reg  <= inst_cnt_next;
        end
    end

    assign imem_req_valid = (state_reg == REQ);
    assign imem_req_addr  = fetch_pc_reg;
    assign inst_valid     = (state_reg == HOLD);
    assign inst           = inst_reg;
    assign pc             = pc_reg;
    assign snpc           = snpc_reg;
    assign fetch_err      = fetch_err_reg;
    assign inst_cnt       = inst_cnt_reg;

endmodule

// File: tb/tb_ysyx_22041461_ifu.sv
// Bench for the fetch unit: a scripted memory/decode partner plus a per-instruction
// reference model of fetch address, retire count and sticky error.
module tb_ysyx_22041461_ifu;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] snpc;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        fetch_err;
    logic [63:0] inst_cnt;

    int          n_checks = 0;
    int          n_fail = 0;

    // reference model
    logic [63:0] exp_fetch;
    logic [63:0] exp_cnt;
    logic        exp_err;

    ysyx_22041461_ifu #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .pc(pc), .snpc(snpc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_err(fetch_err), .inst_cnt(inst_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_fetch = RESET_PC; exp_cnt = 64'd0; exp_err = 1'b0;
    endtask

    // One instruction end to end: request stall, response delay, decode stall, retire.
    task automatic fetch_one(input int req_stall, input int rsp_delay, input int hold_stall,
                             input logic rv, input logic [63:0] rpc);
        logic [31:0] exp_inst;
        exp_inst = mem_word(exp_fetch);
        for (int i = 0; i < 8 && !imem_req_valid; i++) @(negedge clk);
        n_checks++;
        if ({imem_req_valid, imem_req_addr, inst_valid, inst} !== {1'b1, exp_fetch, 1'b0, NOP_INST}) begin
            n_fail++;
            $display("FAIL req_issue: got v=%b addr=%h iv=%b inst=%h want v=1 addr=%h iv=0 inst=%h",
                     imem_req_valid, imem_req_addr, inst_valid, inst, exp_fetch, NOP_INST);
        end
        for (int i = 0; i < req_stall; i++) begin
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
            @(negedge clk);
            n_checks++;
            if ({imem_req_valid, imem_req_addr, inst_valid} !== {1'b1, exp_fetch, 1'b0}) begin
                n_fail++;
                $display("FAIL req_hold: got v=%b addr=%h iv=%b want v=1 addr=%h iv=0",
                         imem_req_valid, imem_req_addr, inst_valid, exp_fetch);
            end
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        n_checks++;
        if ({imem_req_valid, inst_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL wait_entry: got req_valid=%b inst_valid=%b want 0 0", imem_req_valid, inst_valid);
        end
        for (int i = 0; i < rsp_delay; i++) begin
            @(negedge clk);
            n_checks++;
            if ({imem_req_valid, inst_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL wait_idle: got req_valid=%b inst_valid=%b want 0 0", imem_req_valid, inst_valid);
            end
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = exp_inst;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        n_checks++;
        if ({inst_valid, inst, pc, snpc} !== {1'b1, exp_inst, exp_fetch, exp_fetch + 64'd4}) begin
            n_fail++;
            $display("FAIL present: got iv=%b inst=%h pc=%h snpc=%h want iv=1 inst=%h pc=%h snpc=%h",
                     inst_valid, inst, pc, snpc, exp_inst, exp_fetch, exp_fetch + 64'd4);
        end
        for (int i = 0; i < hold_stall; i++) begin
            inst_ready = 1'b0;
            redirect_valid = 1'b1;
            redirect_pc = {$urandom, $urandom};
            @(negedge clk);
            n_checks++;
            if ({inst_valid, inst, pc, imem_req_valid, inst_cnt} !== {1'b1, exp_inst, exp_fetch, 1'b0, exp_cnt}) begin
                n_fail++;
                $display("FAIL hold_stable: got iv=%b inst=%h pc=%h rv=%b cnt=%0d want iv=1 inst=%h pc=%h rv=0 cnt=%0d",
                         inst_valid, inst, pc, imem_req_valid, inst_cnt, exp_inst, exp_fetch, exp_cnt);
            end
        end
        inst_ready = 1'b1;
        redirect_valid = rv;
        redirect_pc = rpc;
        @(negedge clk);
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        exp_cnt = exp_cnt + 64'd1;
        if (rv) begin
            exp_fetch = rpc & ~64'd3;
            if (rpc[1:0] != 2'b00) exp_err = 1'b1;
        end else begin
            exp_fetch = exp_fetch + 64'd4;
        end
        n_checks++;
        if ({inst_valid, inst, inst_cnt, fetch_err, imem_req_valid, imem_req_addr} !==
            {1'b0, NOP_INST, exp_cnt, exp_err, 1'b1, exp_fetch}) begin
            n_fail++;
            $display("FAIL retire: got iv=%b inst=%h cnt=%0d err=%b rv=%b addr=%h want iv=0 inst=%h cnt=%0d err=%b rv=1 addr=%h",
                     inst_valid, inst, inst_cnt, fetch_err, imem_req_valid, imem_req_addr,
                     NOP_INST, exp_cnt, exp_err, exp_fetch);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({imem_req_valid, imem_req_addr, inst_valid, inst, pc, snpc, fetch_err, inst_cnt} !==
            {1'b0, RESET_PC, 1'b0, NOP_INST, RESET_PC, RESET_PC + 64'd4, 1'b0, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got rv=%b addr=%h iv=%b inst=%h pc=%h snpc=%h err=%b cnt=%0d",
                     imem_req_valid, imem_req_addr, inst_valid, inst, pc, snpc, fetch_err, inst_cnt);
        end
        @(negedge clk);
        n_checks++;
        if ({imem_req_valid, imem_req_addr, inst_valid, inst} !== {1'b1, RESET_PC, 1'b0, NOP_INST}) begin
            n_fail++;
            $display("FAIL first_req: got rv=%b addr=%h iv=%b inst=%h want rv=1 addr=%h iv=0 inst=%h",
                     imem_req_valid, imem_req_addr, inst_valid, inst, RESET_PC, NOP_INST);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h0010_0093;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        n_checks++;
        if ({inst_valid, inst, pc, snpc} !== {1'b1, 32'h0010_0093, 64'h8000_0000, 64'h8000_0004}) begin
            n_fail++;
            $display("FAIL seq_cycle3: got iv=%b inst=%h pc=%h snpc=%h want iv=1 inst=00100093 pc=80000000 snpc=80000004",
                     inst_valid, inst, pc, snpc);
        end
        @(negedge clk);
        inst_ready = 1'b0;
        n_checks++;
        if ({inst_cnt, imem_req_valid, imem_req_addr} !== {64'd1, 1'b1, 64'h8000_0004}) begin
            n_fail++;
            $display("FAIL seq_next: got cnt=%0d rv=%b addr=%h want cnt=1 rv=1 addr=80000004",
                     inst_cnt, imem_req_valid, imem_req_addr);
        end
        exp_fetch = 64'h8000_0004;
        exp_cnt = 64'd1;
        fetch_one(0, 0, 0, 1'b0, 64'd0);
        fetch_one(0, 0, 0, 1'b0, 64'd0);
    endtask

    task automatic test_redirect();
        fetch_one(0, 0, 0, 1'b1, 64'h8000_0100);
        fetch_one(0, 1, 0, 1'b0, 64'd0);
    endtask

    task automatic test_back_to_back();
        fetch_one(4, 5, 3, 1'b0, 64'd0);
        fetch_one(1, 2, 1, 1'b0, 64'd0);
    endtask

    task automatic test_misaligned();
        fetch_one(0, 0, 0, 1'b1, 64'h8000_0102);
        fetch_one(0, 0, 0, 1'b0, 64'd0);
        fetch_one(0, 0, 0, 1'b1, 64'h8000_0200);
    endtask

    task automatic test_wrap();
        fetch_one(0, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch_one(0, 0, 0, 1'b0, 64'd0);
        fetch_one(0, 0, 0, 1'b0, 64'd0);
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 8 && !imem_req_valid; i++) @(negedge clk);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({imem_req_valid, imem_req_addr, inst_valid, inst, pc, snpc, fetch_err, inst_cnt} !==
            {1'b0, RESET_PC, 1'b0, NOP_INST, RESET_PC, RESET_PC + 64'd4, 1'b0, 64'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got rv=%b addr=%h iv=%b inst=%h pc=%h snpc=%h err=%b cnt=%0d",
                     imem_req_valid, imem_req_addr, inst_valid, inst, pc, snpc, fetch_err, inst_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_fetch = RESET_PC; exp_cnt = 64'd0; exp_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = $urandom;
            @(negedge clk);
            n_checks++;
            if ({inst_valid, inst, imem_req_addr} !== {1'b0, NOP_INST, RESET_PC}) begin
                n_fail++;
                $display("FAIL stray_rsp: got iv=%b inst=%h addr=%h want iv=0 inst=%h addr=%h",
                         inst_valid, inst, imem_req_addr, NOP_INST, RESET_PC);
            end
        end
        imem_rsp_valid = 1'b0;
        fetch_one(0, 0, 0, 1'b0, 64'd0);
    endtask

    task automatic test_random();
        logic        rv;
        logic [63:0] rpc;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            rv  = 1'($urandom % 2);
            rpc = {$urandom, $urandom};
            if (($urandom % 4) != 0) rpc[1:0] = 2'b00;
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), rv, rpc);
        end
    endtask

    initial begin
        exp_fetch = RESET_PC; exp_cnt = 64'd0; exp_err = 1'b0;
        test_reset();
        test_sequential();
        test_redirect();
        test_back_to_back();
        test_misaligned();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
